// File: rtl/readout_pkg.sv
// Shared constants for the channel readout controller: frame tags, FSM encoding, event counter width.
// Optional trailer word enabled by defining READOUT_TRAILER_EN.
package readout_pkg;

    localparam logic [3:0] HDR_TAG = 4'hA;
    localparam logic [3:0] TRL_TAG = 4'hE;

`ifdef READOUT_TRAILER_EN
    localparam bit TRAILER_EN = 1'b1;
    localparam int SPACE_PAD  = 3;
`else
    localparam bit TRAILER_EN = 1'b0;
    localparam int SPACE_PAD  = 2;
`endif

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_SPACE,
        ST_HEADER,
        ST_READ,
        ST_DRAIN,
        ST_TRAILER,
        ST_FINISH
    } state_t;

    // The event counter fills whatever the 4-bit tag leaves of a word.
    function automatic int evt_cnt_width(input int width);
        return width - 4;
    endfunction

endpackage

// File: rtl/ro_sync_fifo.sv
// First-word-fall-through synchronous FIFO with free-slot count, used to buffer tagged readout words.
module ro_sync_fifo #(
    parameter int AW = 9,
    parameter int DW = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_wr_en,
    input  logic [DW-1:0] i_wr_data,
    input  logic          i_rd_en,
    output logic [DW-1:0] o_rd_data,
    output logic          o_empty,
    output logic [AW:0]   o_free_count
);

    localparam logic [AW:0] FULL_CNT = {1'b1, {AW{1'b0}}};

    logic [DW-1:0] r_mem [2**AW];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign w_pop  = i_rd_en && (r_count != '0);
    assign w_push = i_wr_en && (r_count != FULL_CNT);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Head word is read straight from the array so it is visible the cycle after the write.
    assign o_rd_data    = r_mem[r_rd_ptr];
    assign o_empty      = (r_count == '0);
    assign o_free_count = FULL_CNT - r_count;

endmodule

// File: rtl/channel_readout_ctrl.sv
// Reader end of the channel readout interface: sequences one channel read per event and streams framed words.
// Define READOUT_TRAILER_EN to append an XOR trailer word to every frame.
module channel_readout_ctrl
    import readout_pkg::*;
#(
    parameter int SIZE    = 8,
    parameter int WIDTH   = 16,
    parameter int RD_LAT  = 2,
    parameter int FIFO_AW = 9
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             start,
    input  logic [SIZE-1:0]  howmany_cfg,
    input  logic [SIZE-1:0]  offset_cfg,
    output logic             rd_request,
    output logic [SIZE-1:0]  howmany,
    output logic [SIZE-1:0]  offset,
    input  logic [WIDTH-1:0] ch_dout,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             out_sop,
    output logic             out_eop,
    output logic             busy,
    output logic             dropped
);

    localparam int          EW         = evt_cnt_width(WIDTH);
    localparam logic [2:0]  DRAIN_LAST = 3'(RD_LAT - 1);
    localparam state_t      ST_POST    = TRAILER_EN ? ST_TRAILER : ST_FINISH;

    state_t            r_state;
    state_t            w_state_next;
    logic              r_pending;
    logic [SIZE-1:0]   r_howmany;
    logic [SIZE-1:0]   r_offset;
    logic [SIZE-1:0]   r_cnt;
    logic [2:0]        r_drain_cnt;
    logic [EW-1:0]     r_evt_cnt;
    logic [EW-1:0]     r_xor;
    logic [RD_LAT-1:0] r_req_dly;
    logic [RD_LAT-1:0] r_last_dly;

    logic              w_consume;
    logic              w_hdr_push;
    logic              w_trl_push;
    logic              w_rd_req;
    logic              w_read_last;
    logic              w_cap;
    logic              w_cap_last;
    logic              w_wr_en;
    logic [WIDTH+1:0]  w_wr_data;
    logic [WIDTH+1:0]  w_rd_data;
    logic              w_empty;
    logic              w_pop;
    logic [FIFO_AW:0]  w_free;
    logic [FIFO_AW:0]  w_need;
    logic [RD_LAT:0]   w_req_shift;
    logic [RD_LAT:0]   w_last_shift;

    assign w_need = (FIFO_AW + 1)'(r_howmany) + (FIFO_AW + 1)'(SPACE_PAD);

    always_comb begin
        w_state_next = r_state;
        w_consume    = 1'b0;
        w_hdr_push   = 1'b0;
        w_trl_push   = 1'b0;
        w_rd_req     = 1'b0;
        w_read_last  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_pending) begin
                    w_consume    = 1'b1;
                    w_state_next = ST_WAIT_SPACE;
                end
            end
            ST_WAIT_SPACE: begin
                if (w_free >= w_need) w_state_next = ST_HEADER;
            end
            ST_HEADER: begin
                w_hdr_push   = 1'b1;
                w_state_next = (r_howmany == '0) ? ST_POST : ST_READ;
            end
            ST_READ: begin
                w_rd_req = 1'b1;
                if (r_cnt == r_howmany - 1'b1) begin
                    w_read_last  = 1'b1;
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (r_drain_cnt == DRAIN_LAST) w_state_next = ST_POST;
            end
            ST_TRAILER: begin
                w_trl_push   = 1'b1;
                w_state_next = ST_FINISH;
            end
            ST_FINISH: begin
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_pending   <= 1'b0;
            r_howmany   <= '0;
            r_offset    <= '0;
            r_cnt       <= '0;
            r_drain_cnt <= '0;
            r_evt_cnt   <= '0;
            r_xor       <= '0;
        end else begin
            r_state <= w_state_next;
            // A start coinciding with consumption re-arms the flag for the next event.
            if (start)          r_pending <= 1'b1;
            else if (w_consume) r_pending <= 1'b0;
            if (w_consume) begin
                r_howmany <= howmany_cfg;
                r_offset  <= offset_cfg;
            end
            r_cnt       <= (r_state == ST_READ && !w_read_last) ? r_cnt + 1'b1 : '0;
            r_drain_cnt <= (r_state == ST_DRAIN) ? r_drain_cnt + 1'b1 : '0;
            if (w_hdr_push)  r_xor <= '0;
            else if (w_cap)  r_xor <= r_xor ^ ch_dout[EW-1:0];
            if (r_state == ST_FINISH) r_evt_cnt <= r_evt_cnt + 1'b1;
        end
    end

    // Request and last-sample markers travel alongside the channel latency.
    assign w_req_shift  = {r_req_dly, w_rd_req};
    assign w_last_shift = {r_last_dly, w_read_last};

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_req_dly  <= '0;
            r_last_dly <= '0;
        end else begin
            r_req_dly  <= w_req_shift[RD_LAT-1:0];
            r_last_dly <= w_last_shift[RD_LAT-1:0];
        end
    end

    assign w_cap      = r_req_dly[RD_LAT-1];
    assign w_cap_last = r_last_dly[RD_LAT-1];

    // Header, samples and trailer occupy disjoint cycles, so a simple priority mux suffices.
    always_comb begin
        w_wr_en   = w_hdr_push | w_trl_push | w_cap;
        w_wr_data = {1'b0, w_cap_last && !TRAILER_EN, ch_dout};
        if (w_hdr_push) begin
            w_wr_data = {1'b1, (r_howmany == '0) && !TRAILER_EN, HDR_TAG, r_evt_cnt};
        end else if (w_trl_push) begin
            w_wr_data = {1'b0, 1'b1, TRL_TAG, r_xor};
        end
    end

    ro_sync_fifo #(
        .AW (FIFO_AW),
        .DW (WIDTH + 2)
    ) u_fifo (
        .clk          (CLK),
        .rst          (RESET),
        .i_wr_en      (w_wr_en),
        .i_wr_data    (w_wr_data),
        .i_rd_en      (w_pop),
        .o_rd_data    (w_rd_data),
        .o_empty      (w_empty),
        .o_free_count (w_free)
    );

    assign out_valid  = !w_empty;
    assign w_pop      = out_valid && out_ready;
    assign out_data   = out_valid ? w_rd_data[WIDTH-1:0] : '0;
    assign out_sop    = out_valid && w_rd_data[WIDTH+1];
    assign out_eop    = out_valid && w_rd_data[WIDTH];
    assign rd_request = w_rd_req;
    assign howmany    = r_howmany;
    assign offset     = r_offset;
    assign busy       = (r_state != ST_IDLE);
    assign dropped    = start && r_pending && busy;

endmodule

// File: doc/channel_readout_ctrl.md
Name: channel_readout_ctrl

Overview:
- Reader end of the channel readout interface. It sequences one digitizer channel after an event is flagged, drives the channel's read request, `howmany` and `offset`, and captures the returned samples.
- Captured samples are framed with a header word in an internal FIFO. The frame is streamed downstream over a valid/ready handshake toward the packet/link builder.

Parameters:
- SIZE, 8: channel address width; also the width of `howmany` and `offset`.
- WIDTH, 16: sample and output word width. Must be >= 8.
- RD_LAT, 2: cycles from an `rd_request`-high cycle to the matching valid word on `ch_dout`. Legal range 1..7.
- FIFO_AW, 9: local FIFO address width. Must satisfy 2^FIFO_AW >= 2^SIZE + 2.

Ports:
- CLK, in, 1: clock; everything is sampled on the rising edge.
- RESET, in, 1: asynchronous, active-high reset.
- start, in, 1: event-ready pulse; requests one readout.
- howmany_cfg, in, SIZE: number of samples to read.
- offset_cfg, in, SIZE: pre-trigger offset to apply.
- rd_request, out, 1: read request to the channel.
- howmany, out, SIZE: value latched at readout start, driven to the channel.
- offset, out, SIZE: value latched at readout start, driven to the channel.
- ch_dout, in, WIDTH: channel sample data.
- out_data, out, WIDTH: stream data.
- out_valid, out, 1: stream valid.
- out_ready, in, 1: stream ready from downstream.
- out_sop, out, 1: high on the header word.
- out_eop, out, 1: high on the last word of a frame.
- busy, out, 1: high in any state other than IDLE.
- dropped, out, 1: one-cycle pulse when a start is discarded.

Behaviour:
- Reset values: every output is 0; `evt_cnt` = 0; FIFO empty; `pending` = 0; state IDLE.
- Start handling:
  - `start` sets the sticky `pending` flag.
  - A start arriving while `pending` is already set and the controller is busy produces `dropped` = 1 for one cycle; `pending` stays set.
  - `start` in the same cycle that IDLE consumes `pending` is treated as a new pending request.
- State machine:
  - IDLE: when `pending` = 1, clear `pending`, latch `howmany_cfg`/`offset_cfg` into `howmany`/`offset`, go to WAIT_SPACE.
  - WAIT_SPACE: wait until FIFO free slots >= `howmany` + 2, then go to HEADER.
  - HEADER: push the header word `{4'hA, evt_cnt[WIDTH-5:0]}` with its sop tag set. If `howmany` = 0 go to FINISH, otherwise go to READ.
  - READ: hold `rd_request` = 1 for exactly `howmany` consecutive cycles, then drop it and go to DRAIN.
  - DRAIN: wait RD_LAT cycles so all in-flight words are captured, then go to FINISH.
  - FINISH: increment `evt_cnt` (wraps modulo 2^(WIDTH-4)), return to IDLE.
- Capture:
  - An RD_LAT-deep shift register carries `rd_request`. The word on `ch_dout` is pushed to the FIFO when the delayed bit is 1.
  - Capture is independent of `out_ready`. Overflow cannot occur because of the WAIT_SPACE rule.
- End of frame: the eop tag is set on the last word pushed for the event. That is the last sample, or the header when `howmany` = 0, or the trailer when the optional trailer is enabled.
- Output stream:
  - The FIFO is first-word-fall-through. `out_valid` = !empty.
  - A word transfers when `out_valid && out_ready`.
  - `out_data`, `out_sop` and `out_eop` are held stable while `out_valid && !out_ready`.
- Throughput: one word per cycle on both the capture and stream sides. A simultaneous push and pop in the same cycle is legal.
- RESET mid-frame: the FIFO is flushed immediately, `rd_request` goes to 0 asynchronously, and `evt_cnt` returns to 0. No partial frame is emitted after reset is released.

Optional Feature:
- Macro: READOUT_TRAILER_EN.
- Defined:
  - After DRAIN, a TRAILER state pushes `{4'hE, xor_all_samples[WIDTH-5:0]}` with the eop tag set.
  - The WAIT_SPACE threshold becomes `howmany` + 3.
  - For `howmany` = 0 the trailer still follows the header.
- Undefined: no trailer, and eop is set as described under End of frame.

Decomposition:
- Shared package `readout_pkg` holds:
  - header and trailer tag constants (4'hA, 4'hE);
  - state encoding constants (IDLE, WAIT_SPACE, HEADER, READ, DRAIN, TRAILER, FINISH);
  - the `evt_cnt` width rule.
- One sub-module, `ro_sync_fifo`: parameterized (AW, DW = WIDTH+2 for sop/eop tags), first-word-fall-through, with `free_count` output.

Test Plan:
- Basic frame: `howmany_cfg` = 4, `offset_cfg` = 2, RD_LAT = 2, channel returns 0x0101..0x0104, `out_ready` = 1. Required: `rd_request` high for 4 cycles; stream is 0xA000(sop), 0x0101, 0x0102, 0x0103, 0x0104(eop); `howmany` = 4 and `offset` = 2 on the channel ports.
- Backpressure: same event with `out_ready` toggling every cycle. Required: all 5 words delivered in order, data held stable while stalled, no loss.
- Zero length: `howmany_cfg` = 0. Required: `rd_request` never asserted; single word 0xA000 with both sop and eop; `evt_cnt` increments.
- Busy starts: second `start` during READ, then a third. Required: second frame follows with header 0xA001; third start gives `dropped` = 1 for one cycle.
- Space gating: `howmany_cfg` = 255, `out_ready` = 0, two events. Required: the second event stays in WAIT_SPACE until enough words drain; with READOUT_TRAILER_EN the trailer equals 0xE000 | (XOR of samples & 0xFFF).
- Reset mid-operation: assert RESET mid-READ with `howmany_cfg` = 10. Required: `rd_request` = 0 and `out_valid` = 0 immediately; next event's header is 0xA000.
